operand_fetch: RTL

- Reader-side client of the CPU register file; sits between decode and execute.
- Accepts decoded instructions on a valid/ready handshake and drives the register file read ports.
- Absorbs the register file's 1-cycle registered read latency and forwards in-flight writeback data.
- Presents operand-complete instructions to execute through a small output buffer on a valid/ready handshake.

---
 rtl/operand_fetch_pkg.sv | 33 +++
 rtl/operand_fetch_if.sv | 48 ++++
 rtl/of_operand_buffer.sv | 77 +++++++
 rtl/operand_fetch.sv | 126 ++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: buffered instruction entry,
// writeback snoop record and the forwarding match helper.
package operand_fetch_pkg;

  localparam int unsigned OF_ADDR_W = 6;
  localparam int unsigned OF_XLEN   = 32;

  typedef logic [OF_ADDR_W-1:0] of_addr_t;
  typedef logic [OF_XLEN-1:0]   of_data_t;

  typedef struct packed {
    of_addr_t rs1;
    of_addr_t rs2;
    logic     rs1_en;
    logic     rs2_en;
    of_addr_t rd;
    logic     rd_en;
    of_data_t rs1_data;
    of_data_t rs2_data;
  } of_entry_t;

  typedef struct packed {
    logic     valid;
    of_addr_t addr;
    of_data_t data;
  } wb_snoop_t;

  // x0 is hardwired to zero, so a writeback to address 0 never forwards.
  function automatic logic fwd_match(input wb_snoop_t wb, input of_addr_t addr, input logic en);
    return wb.valid && en && (addr != '0) && (wb.addr == addr);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode / register-file / writeback / execute signal bundle around operand fetch.
// master = surrounding pipeline, slave = operand_fetch.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = OF_ADDR_W,
  parameter int unsigned XLEN      = OF_XLEN
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_SIZE-1:0] in_rs1;
  logic [ADDR_SIZE-1:0] in_rs2;
  logic                 in_rs1_en;
  logic                 in_rs2_en;
  logic [ADDR_SIZE-1:0] in_rd;
  logic                 in_rd_en;
  logic                 rf_read_enable1;
  logic                 rf_read_enable2;
  logic [ADDR_SIZE-1:0] rf_read_addr1;
  logic [ADDR_SIZE-1:0] rf_read_addr2;
  logic [XLEN-1:0]      rf_read_data1;
  logic [XLEN-1:0]      rf_read_data2;
  logic                 wb_valid;
  logic [ADDR_SIZE-1:0] wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_rs1_data;
  logic [XLEN-1:0]      out_rs2_data;
  logic [ADDR_SIZE-1:0] out_rd;
  logic                 out_rd_en;

  modport master (
    output flush, in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en,
           rf_read_data1, rf_read_data2, wb_valid, wb_addr, wb_data, out_ready,
    input  in_ready, rf_read_enable1, rf_read_enable2, rf_read_addr1, rf_read_addr2,
           out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en
  );

  modport slave (
    input  flush, in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en,
           rf_read_data1, rf_read_data2, wb_valid, wb_addr, wb_data, out_ready,
    output in_ready, rf_read_enable1, rf_read_enable2, rf_read_addr1, rf_read_addr2,
           out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en
  );

endinterface

// File: rtl/of_operand_buffer.sv
// Output FIFO of operand-complete entries; held operands are refreshed from
// the writeback snoop when OPERAND_FETCH_BYPASS_EN is defined.
module of_operand_buffer
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  of_entry_t        push_entry_i,
  input  logic             pop_i,
`ifdef OPERAND_FETCH_BYPASS_EN
  input  wb_snoop_t        wb_i,
`endif
  output of_entry_t        head_o,
  output logic [CNT_W-1:0] occ_o
);

  of_entry_t        mem_q [DEPTH];
  of_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
`ifdef OPERAND_FETCH_BYPASS_EN
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fwd_match(wb_i, mem_q[i].rs1, mem_q[i].rs1_en)) mem_d[i].rs1_data = wb_i.data;
      if (fwd_match(wb_i, mem_q[i].rs2, mem_q[i].rs2_en)) mem_d[i].rs2_data = wb_i.data;
    end
`endif
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // The pushed entry is already resolved against this cycle's writeback.
      if (push_i) begin
        mem_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push_i && pop_i) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign occ_o  = cnt_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: issues register file reads, absorbs the 1-cycle read latency and
// buffers resolved operands for execute. Forwarding gated by OPERAND_FETCH_BYPASS_EN.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = OF_ADDR_W,
  parameter int unsigned XLEN       = OF_XLEN,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  operand_fetch_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);

  logic             f_vld_q;
  of_entry_t        f_q, f_d;
  of_entry_t        push_entry, head;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0]   fill;
  logic [XLEN-1:0]  op1, op2;
  logic             acc, pop, in_ready, out_valid;

  assign out_valid = (occ != '0);
  assign pop       = out_valid && bus.out_ready;
  assign fill      = {1'b0, occ} + {{CNT_W{1'b0}}, f_vld_q};
  assign in_ready  = !bus.flush && ((fill < (CNT_W + 1)'(OBUF_DEPTH)) || pop);
  assign acc       = bus.in_valid && in_ready;

  assign bus.in_ready        = in_ready;
  assign bus.rf_read_enable1 = acc && bus.in_rs1_en;
  assign bus.rf_read_enable2 = acc && bus.in_rs2_en;
  assign bus.rf_read_addr1   = ADDR_SIZE'(bus.in_rs1);
  assign bus.rf_read_addr2   = ADDR_SIZE'(bus.in_rs2);

  always_comb begin
    f_d        = '0;
    f_d.rs1    = bus.in_rs1;
    f_d.rs2    = bus.in_rs2;
    f_d.rs1_en = bus.in_rs1_en;
    f_d.rs2_en = bus.in_rs2_en;
    f_d.rd     = bus.in_rd;
    f_d.rd_en  = bus.in_rd_en;
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  wb_snoop_t wb_now, wb_q;
  assign wb_now = '{valid: bus.wb_valid, addr: bus.wb_addr, data: bus.wb_data};

  // The issue-cycle writeback lands on the same edge as the RF read, so the
  // read data misses it; wb_q carries it into the F cycle.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (f_q.rs1_en && (f_q.rs1 != '0)) begin
      if (fwd_match(wb_now, f_q.rs1, 1'b1))    op1 = wb_now.data;
      else if (fwd_match(wb_q, f_q.rs1, 1'b1)) op1 = wb_q.data;
      else                                     op1 = bus.rf_read_data1;
    end
    if (f_q.rs2_en && (f_q.rs2 != '0)) begin
      if (fwd_match(wb_now, f_q.rs2, 1'b1))    op2 = wb_now.data;
      else if (fwd_match(wb_q, f_q.rs2, 1'b1)) op2 = wb_q.data;
      else                                     op2 = bus.rf_read_data2;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_valid, bus.wb_addr, bus.wb_data};

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (f_q.rs1_en && (f_q.rs1 != '0)) op1 = bus.rf_read_data1;
    if (f_q.rs2_en && (f_q.rs2 != '0)) op2 = bus.rf_read_data2;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_vld_q <= 1'b0;
      f_q     <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
      wb_q    <= '0;
`endif
    end else begin
      f_vld_q <= acc;
      if (acc) begin
        f_q  <= f_d;
`ifdef OPERAND_FETCH_BYPASS_EN
        wb_q <= wb_now;
`endif
      end
    end
  end

  always_comb begin
    push_entry          = f_q;
    push_entry.rs1_data = op1;
    push_entry.rs2_data = op2;
  end

  of_operand_buffer #(.DEPTH(OBUF_DEPTH)) u_obuf (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (bus.flush),
    .push_i       (f_vld_q),
    .push_entry_i (push_entry),
    .pop_i        (pop),
`ifdef OPERAND_FETCH_BYPASS_EN
    .wb_i         (wb_now),
`endif
    .head_o       (head),
    .occ_o        (occ)
  );

  logic unused_head;
  assign unused_head = ^{head.rs1, head.rs2, head.rs1_en, head.rs2_en};

  assign bus.out_valid    = out_valid;
  assign bus.out_rs1_data = head.rs1_data;
  assign bus.out_rs2_data = head.rs2_data;
  assign bus.out_rd       = head.rd;
  assign bus.out_rd_en    = head.rd_en;

endmodule
